// File: rtl/paddle_control.sv
// Paddle position controller.
//
// Moves a paddle along the vertical axis in whole-pixel steps. The paddle follows either two
// debounced push buttons or, in AI mode, the ball position with a tolerance band. Every state
// update is qualified by the single-cycle frame enable `tick`.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous active-low reset
//   tick       frame enable; registers update only when high
//   btn_up     raw button, requests paddle_x to decrease
//   btn_down   raw button, requests paddle_x to increase
//   ai_enable  1 = track ball_x, 0 = follow the buttons
//   ball_x     top edge of the ball
//   paddle_x   registered top edge of the paddle
//   moving     high while the FSM is in a move state
//   at_limit   high when paddle_x sits on either legal extreme
module paddle_control #(
  parameter int unsigned PADDLE_HEIGHT = 40,
  parameter int unsigned MIN_X         = 0,
  parameter int unsigned MAX_X         = 239,
  parameter int unsigned START_X       = (MAX_X - MIN_X - PADDLE_HEIGHT) / 2,
  parameter int unsigned BALL_SIZE     = 10,
  parameter int unsigned STEP_DIV      = 4,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned DEADBAND      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       ai_enable,
  input  logic [7:0] ball_x,
  output logic [7:0] paddle_x,
  output logic       moving,
  output logic       at_limit
);

  localparam int unsigned DivW = $clog2(STEP_DIV + 1);
  localparam int unsigned DbW  = $clog2(DEBOUNCE + 1);

  localparam logic [7:0] LoPos    = 8'(MIN_X);
  localparam logic [7:0] HiPos    = 8'(MAX_X - PADDLE_HEIGHT);
  localparam logic [7:0] StartPos = 8'(START_X);

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown
  } state_e;

  state_e            state_q, state_d;
  state_e            req_state;
  logic              mode_q, mode_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [7:0]        pos_q, pos_d;

  // Index 0 is btn_up, index 1 is btn_down.
  logic [1:0]        raw;
  logic [1:0]        deb_q, deb_d;
  logic [DbW-1:0]    cnt_q [2];
  logic [DbW-1:0]    cnt_d [2];

  logic [8:0]        target;
  logic [8:0]        center;
  logic              ai_up;
  logic              ai_down;

  assign raw = {btn_down, btn_up};

  // Extra headroom bit keeps the deadband sums from overflowing.
  assign target  = {1'b0, ball_x} + 9'(BALL_SIZE / 2);
  assign center  = {1'b0, pos_q} + 9'(PADDLE_HEIGHT / 2);
  assign ai_up   = {1'b0, center} > ({1'b0, target} + 10'(DEADBAND));
  assign ai_down = ({1'b0, center} + 10'(DEADBAND)) < {1'b0, target};

  always_comb begin
    req_state = StIdle;
    if (mode_q) begin
      if (ai_up) begin
        req_state = StMoveUp;
      end else if (ai_down) begin
        req_state = StMoveDown;
      end
    end else begin
      unique case (deb_q)
        2'b01:   req_state = StMoveUp;
        2'b10:   req_state = StMoveDown;
        default: req_state = StIdle;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    pos_d   = pos_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;

    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != deb_q[i]) begin
          if (cnt_q[i] + 1'b1 == DbW'(DEBOUNCE)) begin
            deb_d[i] = raw[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end

      if (ai_enable != mode_q) begin
        // A mode switch only resynchronises; motion resumes from the next tick.
        mode_d  = ai_enable;
        state_d = StIdle;
        div_d   = '0;
      end else begin
        state_d = req_state;
        if (req_state != state_q || req_state == StIdle) begin
          div_d = '0;
        end else if (div_q + 1'b1 == DivW'(STEP_DIV)) begin
          div_d = '0;
          // Clamped steps are dropped but the FSM keeps its move state.
          if (state_q == StMoveUp) begin
            if (pos_q > LoPos) begin
              pos_d = pos_q - 1'b1;
            end
          end else begin
            if (pos_q < HiPos) begin
              pos_d = pos_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      div_q    <= '0;
      pos_q    <= StartPos;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      pos_q    <= pos_d;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign paddle_x = pos_q;
  assign moving   = (state_q != StIdle);
  assign at_limit = (pos_q == LoPos) || (pos_q == HiPos);

endmodule
